// File: rtl/commit_stream_arbiter.sv
// rtl/commit_stream_arbiter.sv - round-robin, packet-atomic merge of commit streams into one registered stream
// Optional feature macro: COMMIT_ARB_PERF_EN (stall/bubble performance counters)
module commit_stream_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 64,
  localparam int SELW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]       in_sop,
  input  logic [NUM_INPUTS-1:0]       in_eop,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        out_valid,
  output logic [DATAW-1:0]            out_data,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [SELW-1:0]             out_sel,
  input  logic                        out_ready
`ifdef COMMIT_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_stall_cycles,
  output logic [31:0]                 perf_bubble_cycles
`endif
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]       state;
  logic [SELW-1:0]  owner;
  logic [SELW-1:0]  rr_ptr;
  logic             can_load;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  scan_idx;
  logic             xfer;
  logic [DATAW-1:0] sel_data;
  logic             sel_sop;
  logic             sel_eop;

  assign can_load = !out_valid || out_ready;
  assign xfer     = grant_any && can_load && !reset;

  // Scan from farthest to nearest so the stream closest after rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (state == ST_LOCKED) begin
      grant_any = in_valid[owner];
      grant_idx = owner;
    end else begin
      for (int k = NUM_INPUTS; k >= 1; k--) begin
        scan_idx = SELW'((int'(rr_ptr) + k) % NUM_INPUTS);
        if (in_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == SELW'(i)) begin
        sel_data    = in_data[i*DATAW +: DATAW];
        sel_sop     = in_sop[i];
        sel_eop     = in_eop[i];
        in_ready[i] = xfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_sel   <= '0;
      state     <= ST_UNLOCKED;
      owner     <= '0;
      rr_ptr    <= SELW'(NUM_INPUTS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sop   <= sel_sop;
      out_eop   <= sel_eop;
      out_sel   <= grant_idx;
      // Priority rotates per packet: only the closing beat moves the pointer.
      if (sel_eop) begin
        state  <= ST_UNLOCKED;
        rr_ptr <= grant_idx;
      end else begin
        state <= ST_LOCKED;
        owner <= grant_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef COMMIT_ARB_PERF_EN
  logic [NUM_INPUTS-1:0] others_valid;

  always_comb begin
    others_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (owner != SELW'(i)) others_valid[i] = in_valid[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles  <= '0;
      perf_bubble_cycles <= '0;
    end else begin
      if (out_valid && !out_ready && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (state == ST_LOCKED && !in_valid[owner] && (|others_valid) &&
          perf_bubble_cycles != 32'hFFFF_FFFF)
        perf_bubble_cycles <= perf_bubble_cycles + 32'd1;
    end
  end
`endif

endmodule
